// File: rtl/game_pkt_pkg.sv
// Shared command codes, packet field offsets and FSM states
// for the game packet decoder.
package game_pkt_pkg;

  localparam logic [7:0] CMD_SET_PIXEL = 8'h01;
  localparam logic [7:0] CMD_FILL_ROW  = 8'h02;
  localparam logic [7:0] CMD_CLEAR     = 8'h03;
  localparam logic [7:0] CMD_SET_SCORE = 8'h04;

  localparam int CMD_LSB  = 32;
  localparam int ARG0_LSB = 24;
  localparam int ARG1_LSB = 16;
  localparam int ARG2_LSB = 8;
  localparam int CHK_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PIXEL,
    ST_ROW,
    ST_CLEAR
  } state_t;

  function automatic logic [7:0] pkt_xsum(input logic [39:0] p);
    return p[CMD_LSB +: 8] ^ p[ARG0_LSB +: 8]
         ^ p[ARG1_LSB +: 8] ^ p[ARG2_LSB +: 8];
  endfunction

endpackage

// File: rtl/game_grid_walker.sv
// Row-major x/y scan counter: load a start cell, step on each
// accepted write, flag the last cell of a row or of the grid.
module game_grid_walker #(
  parameter  int GRID_W = 16,
  parameter  int GRID_H = 16,
  localparam int X_W    = $clog2(GRID_W),
  localparam int Y_W    = $clog2(GRID_H)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  input  logic           step,
  input  logic           wrap,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           done
);

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           last_x;

  assign last_x = (x_q == X_MAX);
  assign done   = last_x && (!wrap || (y_q == Y_MAX));
  assign x      = x_q;
  assign y      = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load) begin
      x_d = load_x;
      y_d = load_y;
    end else if (step) begin
      if (last_x) begin
        x_d = '0;
        if (wrap) y_d = y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/game_pkt_decoder.sv
// Packet decoder: holding slot, command FSM and cell-write port.
// Define GAME_PKT_CHECKSUM_EN to require chk == cmd^arg0^arg1^arg2.
module game_pkt_decoder #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int CNT_W  = 8
) (
  input  logic                      clk50,
  input  logic                      rst,
  input  logic [39:0]               packet,
  input  logic                      dataReceived,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [$clog2(GRID_W)-1:0] wr_x,
  output logic [$clog2(GRID_H)-1:0] wr_y,
  output logic [7:0]                wr_colour,
  output logic [15:0]               score,
  output logic                      busy,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic [CNT_W-1:0]          err_cnt
);

  import game_pkt_pkg::*;

  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);

`ifdef GAME_PKT_CHECKSUM_EN
  localparam int SLOT_LSB = 0;
`else
  localparam int SLOT_LSB = 8;
`endif

  state_t              state_q, state_d;
  logic [39:SLOT_LSB]  slot_q, slot_d;
  logic                slot_full_q, slot_full_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [15:0]         score_q, score_d;
  logic                wr_valid_q, wr_valid_d;
  logic [7:0]          colour_q, colour_d;

  logic [7:0]     cmd, arg0, arg1, arg2;
  logic           chk_ok;
  logic           x0_ok, y0_ok, y1_ok;
  logic           is_pix, is_row, is_clr, is_scr;
  logic           load, step, done;
  logic [X_W-1:0] load_x;
  logic [Y_W-1:0] load_y;

  assign cmd  = slot_q[CMD_LSB  +: 8];
  assign arg0 = slot_q[ARG0_LSB +: 8];
  assign arg1 = slot_q[ARG1_LSB +: 8];
  assign arg2 = slot_q[ARG2_LSB +: 8];

`ifdef GAME_PKT_CHECKSUM_EN
  assign chk_ok = (slot_q[CHK_LSB +: 8] == pkt_xsum(slot_q));
`else
  logic unused_chk;
  assign unused_chk = ^packet[CHK_LSB +: 8];
  assign chk_ok     = 1'b1;
`endif

  // Range is checked on the full byte so large values never alias.
  assign x0_ok = ({1'b0, arg0} < 9'(GRID_W));
  assign y0_ok = ({1'b0, arg0} < 9'(GRID_H));
  assign y1_ok = ({1'b0, arg1} < 9'(GRID_H));

  assign is_pix = chk_ok && (cmd == CMD_SET_PIXEL) && x0_ok && y1_ok;
  assign is_row = chk_ok && (cmd == CMD_FILL_ROW) && y0_ok;
  assign is_clr = chk_ok && (cmd == CMD_CLEAR);
  assign is_scr = chk_ok && (cmd == CMD_SET_SCORE);

  game_grid_walker #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_walker (
    .clk    (clk50),
    .rst    (rst),
    .load   (load),
    .load_x (load_x),
    .load_y (load_y),
    .step   (step),
    .wrap   (state_q == ST_CLEAR),
    .x      (wr_x),
    .y      (wr_y),
    .done   (done)
  );

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    slot_full_d = slot_full_q;
    drop_d      = drop_q;
    err_d       = err_q;
    score_d     = score_q;
    wr_valid_d  = wr_valid_q;
    colour_d    = colour_q;
    load        = 1'b0;
    load_x      = '0;
    load_y      = '0;
    step        = 1'b0;

    if (dataReceived) begin
      if (slot_full_q) begin
        if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
      end else begin
        slot_d      = packet[39:SLOT_LSB];
        slot_full_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (slot_full_q) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        slot_full_d = 1'b0;
        state_d     = ST_IDLE;
        unique case (1'b1)
          is_pix: begin
            load       = 1'b1;
            load_x     = arg0[X_W-1:0];
            load_y     = arg1[Y_W-1:0];
            colour_d   = arg2;
            wr_valid_d = 1'b1;
            state_d    = ST_PIXEL;
          end
          is_row: begin
            load       = 1'b1;
            load_y     = arg0[Y_W-1:0];
            colour_d   = arg1;
            wr_valid_d = 1'b1;
            state_d    = ST_ROW;
          end
          is_clr: begin
            load       = 1'b1;
            colour_d   = arg0;
            wr_valid_d = 1'b1;
            state_d    = ST_CLEAR;
          end
          is_scr: begin
            score_d = {arg0, arg1};
          end
          default: begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
          end
        endcase
      end
      ST_PIXEL: begin
        if (wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_ROW, ST_CLEAR: begin
        if (wr_ready) begin
          step = 1'b1;
          if (done) begin
            wr_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      slot_full_q <= 1'b0;
      drop_q      <= '0;
      err_q       <= '0;
      score_q     <= '0;
      wr_valid_q  <= 1'b0;
      colour_q    <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      slot_full_q <= slot_full_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      score_q     <= score_d;
      wr_valid_q  <= wr_valid_d;
      colour_q    <= colour_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_colour = colour_q;
  assign score     = score_q;
  assign drop_cnt  = drop_q;
  assign err_cnt   = err_q;
  assign busy      = (state_q != ST_IDLE) || slot_full_q;

endmodule
